wb_dma_de_fetch: RTL and testbench
==================================

Name: wb_dma_de_fetch

Overview:
External-descriptor fetch engine, the write-back counterpart of the per-channel register file.
- On request, reads a 4-word descriptor from memory through the DMA master read port.
- Drives the register file's DE update interface (de_csr/de_txsz/de_adr0/de_adr1, their write enables, ptr_set, de_fetch_descr) for the selected channel.
- Sits between the channel arbiter/DMA engine and the wishbone master interface.

Parameters:
TO_CYCLES, 8'd255, watchdog limit in cycles per word (used only with WDMA_DE_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset, sampled on rising clk
de_start  in  1  one-cycle fetch request
ch_sel  in  5  channel to fetch for; latched on accepted de_start
pointer  in  32  channel pointer: [31:4] descriptor address, [0] valid
de_abort  in  1  channel stop; abandons fetch
de_busy  out  1  fetch in progress
de_done  out  1  one-cycle pulse, descriptor fully written back
de_err  out  1  one-cycle pulse, fetch failed
de_ch_sel  out  5  latched channel number
mast_go  out  1  read request to master
mast_we  out  1  tied 0
mast_adr  out  32  read address
mast_din  in  32  read data
mast_drdy  in  1  read data valid
mast_err  in  1  bus error
de_csr  out  32  CSR word, or next pointer when ptr_set
de_txsz  out  12  transfer size
de_adr0  out  32  source address
de_adr1  out  32  destination address
de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we, ptr_set  out  1 each  one-cycle write strobes
de_fetch_descr  out  1  high while busy

Behaviour:
- Reset is synchronous (rst==0 at clk edge): state IDLE; all outputs 0; internal base/index cleared. Reset mid-fetch drops mast_go the next cycle with no strobes.
- Descriptor layout at base = {pointer[31:4],4'h0}:
  - word0 = CSR: [20] EOL, [19:16] mode, [11:0] size
  - word1 = adr0
  - word2 = adr1
  - word3 = next descriptor pointer
- States: IDLE, RD0, RD1, RD2, RD3, FIN.
- IDLE:
  - de_start & pointer[0]: latch base and ch_sel, go to RD0.
  - de_start & !pointer[0]: de_err pulse next cycle, stay IDLE, no bus access.
- RDn:
  - mast_go=1; mast_adr = base + 4*n. Adder is 32-bit and wraps past 0xFFFF_FFF0.
  - mast_go stays high until mast_drdy.
  - On drdy, mast_din is captured and the state advances. The strobe fires in the following cycle (registered, 1-cycle latency).
- Strobes per word:
  - RD0: de_csr=din, de_txsz=din[11:0], de_csr_we=de_txsz_we=1.
  - RD1: de_adr0=din, de_adr0_we=1.
  - RD2: de_adr1=din, de_adr1_we=1.
  - RD3: de_csr=din, ptr_set=1.
- Data outputs hold their value until the next capture.
- FIN: de_done=1 for one cycle, return to IDLE.
- Minimum latency from start to done is 6 cycles (start accepted at edge 0, drdy on every RD cycle, done high in cycle 6).
- de_busy = de_fetch_descr = (state != IDLE). Both are high through FIN.
- de_start while busy is ignored.
- mast_err in any RDn:
  - No strobe for that word; strobes already issued stand.
  - de_err pulses next cycle, go to IDLE.
- de_abort in any RDn or FIN: go to IDLE next cycle, no further strobes, no de_done, no de_err. de_abort in IDLE is ignored.
- Priority in one cycle: rst > mast_err > de_abort > mast_drdy. A word arriving with abort is discarded.
- de_ch_sel stays stable from accept until return to IDLE, and holds after.

Optional Feature:
WDMA_DE_TIMEOUT_EN
- Defined:
  - 8-bit watchdog clears on entry to each RDn and counts while mast_go & !mast_drdy.
  - On reaching TO_CYCLES: mast_go drops, de_err pulses, state goes to IDLE.
- Undefined: no counter; the FSM waits indefinitely for drdy or err.

Test Plan:
- Nominal fetch: pointer=0x0000_1001, ch_sel=3, drdy every cycle, din = 0x0011_0040, 0xA000_0000, 0xB000_0000, 0x0000_2001.
  - mast_adr sequence 0x1000, 0x1004, 0x1008, 0x100C.
  - de_csr_we/de_txsz_we with de_txsz=0x040.
  - de_adr0_we with 0xA000_0000, then de_adr1_we with 0xB000_0000.
  - ptr_set with de_csr=0x0000_2001; de_done 6 cycles after start; de_ch_sel=3.
- Invalid pointer: pointer=0x0000_1000 plus de_start -> de_err one cycle later, mast_go never asserted.
- Wait states: drdy delayed 3 cycles per word -> mast_go and mast_adr held steady, strobe order unchanged, de_done at cycle 18.
- Bus error on word2 -> de_adr0_we seen, no de_adr1_we, no ptr_set, de_err pulse, back to IDLE; a new start then succeeds.
- Abort during RD1 with drdy in the same cycle -> no de_adr0_we, no done/err, IDLE next cycle; reset asserted mid-RD2 -> all outputs 0 at the next edge.
- With WDMA_DE_TIMEOUT_EN and TO_CYCLES=4, drdy never asserted in RD0 -> de_err after 4 stalled cycles, mast_go low; without the macro, mast_go stays high indefinitely.

Source files
------------

// File: rtl/wb_dma_de_fetch.sv
// wb_dma_de_fetch: reads a 4-word external descriptor over the DMA master port and writes it back into the channel register file.
//   clk, rst (sync, active low)   - clock / reset
//   de_start, ch_sel, pointer     - fetch request, channel, descriptor pointer ([31:4] address, [0] valid)
//   de_abort                      - abandon the current fetch
//   de_busy, de_done, de_err      - status: busy, done pulse, error pulse
//   de_ch_sel                     - channel latched at accept
//   mast_go/we/adr, mast_din/drdy/err - master read port
//   de_csr/txsz/adr0/adr1 + *_we, ptr_set, de_fetch_descr - register-file update interface
// Optional: define WDMA_DE_TIMEOUT_EN to add a per-word watchdog of TO_CYCLES stalled cycles.
module wb_dma_de_fetch
`ifdef WDMA_DE_TIMEOUT_EN
#(
    parameter logic [7:0] TO_CYCLES = 8'd255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        de_start,
    input  logic [4:0]  ch_sel,
    input  logic [31:0] pointer,
    input  logic        de_abort,
    output logic        de_busy,
    output logic        de_done,
    output logic        de_err,
    output logic [4:0]  de_ch_sel,
    output logic        mast_go,
    output logic        mast_we,
    output logic [31:0] mast_adr,
    input  logic [31:0] mast_din,
    input  logic        mast_drdy,
    input  logic        mast_err,
    output logic [31:0] de_csr,
    output logic [11:0] de_txsz,
    output logic [31:0] de_adr0,
    output logic [31:0] de_adr1,
    output logic        de_csr_we,
    output logic        de_txsz_we,
    output logic        de_adr0_we,
    output logic        de_adr1_we,
    output logic        ptr_set,
    output logic        de_fetch_descr
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, FIN} state_t;
    state_t state, next;
    logic [27:0] base;
    logic [1:0] idx;
    logic rd, cap, fail, to_hit;
    logic unused_ptr_bits;
    assign unused_ptr_bits = ^pointer[3:1];
`ifdef WDMA_DE_TIMEOUT_EN
    logic [7:0] cnt;
    // cleared whenever the word index changes, so each word gets its own budget
    always_ff @(posedge clk)
        cnt <= (!rst || !rd || next != state) ? 8'd0 : cnt + 8'd1;
    assign to_hit = rd && !mast_drdy && cnt == TO_CYCLES - 8'd1;
`else
    assign to_hit = 1'b0;
`endif
    assign rd = state == RD0 || state == RD1 || state == RD2 || state == RD3;
    assign idx = state == RD1 ? 2'd1 : state == RD2 ? 2'd2 : state == RD3 ? 2'd3 : 2'd0;
    assign mast_go = rd;
    assign mast_we = 1'b0;
    assign mast_adr = rd ? {base, 4'h0} + {28'h0, idx, 2'b00} : 32'h0;
    assign de_busy = state != IDLE;
    assign de_fetch_descr = de_busy;
    // bus error outranks abort, which outranks a data beat in the same cycle
    always_comb begin
        next = state;
        fail = 1'b0;
        cap = 1'b0;
        case (state)
            IDLE: begin
                if (de_start && pointer[0]) next = RD0;
                fail = de_start && !pointer[0];
            end
            FIN: next = IDLE;
            default: begin
                if (mast_err) begin
                    next = IDLE;
                    fail = 1'b1;
                end else if (de_abort) begin
                    next = IDLE;
                end else if (mast_drdy) begin
                    cap = 1'b1;
                    next = state == RD3 ? FIN : state_t'(state + 3'd1);
                end else if (to_hit) begin
                    next = IDLE;
                    fail = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge clk)
        state <= !rst ? IDLE : next;
    always_ff @(posedge clk) begin
        if (!rst) begin
            base <= '0;
            de_ch_sel <= '0;
            de_done <= 1'b0;
            de_err <= 1'b0;
            de_csr <= '0;
            de_txsz <= '0;
            de_adr0 <= '0;
            de_adr1 <= '0;
            de_csr_we <= 1'b0;
            de_txsz_we <= 1'b0;
            de_adr0_we <= 1'b0;
            de_adr1_we <= 1'b0;
            ptr_set <= 1'b0;
        end else begin
            if (state == IDLE && de_start && pointer[0]) begin
                base <= pointer[31:4];
                de_ch_sel <= ch_sel;
            end
            de_done <= state == FIN && !de_abort;
            de_err <= fail;
            de_csr_we <= cap && idx == 2'd0;
            de_txsz_we <= cap && idx == 2'd0;
            de_adr0_we <= cap && idx == 2'd1;
            de_adr1_we <= cap && idx == 2'd2;
            ptr_set <= cap && idx == 2'd3;
            // word0 carries the CSR, word3 the next pointer; both land on de_csr
            if (cap && (idx == 2'd0 || idx == 2'd3)) de_csr <= mast_din;
            if (cap && idx == 2'd0) de_txsz <= mast_din[11:0];
            if (cap && idx == 2'd1) de_adr0 <= mast_din;
            if (cap && idx == 2'd2) de_adr1 <= mast_din;
        end
    end
endmodule

// File: tb/tb_wb_dma_de_fetch.sv
// tb_wb_dma_de_fetch: directed self-checking bench for wb_dma_de_fetch.
module tb_wb_dma_de_fetch;
    logic clk = 1'b0, rst = 1'b0, de_start = 1'b0, de_abort = 1'b0, mast_drdy = 1'b0, mast_err = 1'b0;
    logic [4:0] ch_sel = '0;
    logic [31:0] pointer = '0, mast_din = '0;
    logic de_busy, de_done, de_err, mast_go, mast_we;
    logic [4:0] de_ch_sel;
    logic [31:0] mast_adr, de_csr, de_adr0, de_adr1;
    logic [11:0] de_txsz;
    logic de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we, ptr_set, de_fetch_descr;
    logic [31:0] w [4];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    wb_dma_de_fetch dut (
        .clk(clk), .rst(rst), .de_start(de_start), .ch_sel(ch_sel), .pointer(pointer),
        .de_abort(de_abort), .de_busy(de_busy), .de_done(de_done), .de_err(de_err),
        .de_ch_sel(de_ch_sel), .mast_go(mast_go), .mast_we(mast_we), .mast_adr(mast_adr),
        .mast_din(mast_din), .mast_drdy(mast_drdy), .mast_err(mast_err), .de_csr(de_csr),
        .de_txsz(de_txsz), .de_adr0(de_adr0), .de_adr1(de_adr1), .de_csr_we(de_csr_we),
        .de_txsz_we(de_txsz_we), .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we),
        .ptr_set(ptr_set), .de_fetch_descr(de_fetch_descr)
    );
    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [4:0] stb();
        return {de_csr_we, de_txsz_we, de_adr0_we, de_adr1_we, ptr_set};
    endfunction
    task do_fetch(input logic [31:0] ptr, input logic [4:0] ch, input int ws, input int err_at);
        logic [31:0] base;
        base = {ptr[31:4], 4'h0};
        pointer = ptr;
        ch_sel = ch;
        de_start = 1'b1;
        tick;
        de_start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k <= ws; k++) begin
                chk("go", mast_go, 1);
                chk("adr", mast_adr, base + 32'(4 * n));
                chk("fdescr", de_fetch_descr, 1);
                if (n == 1) begin
                    de_start = 1'b1;
                    ch_sel = ch ^ 5'h5;
                end
                if (k == ws) begin
                    if (n == err_at) mast_err = 1'b1;
                    else begin
                        mast_drdy = 1'b1;
                        mast_din = w[n];
                    end
                end
                tick;
                mast_drdy = 1'b0;
                mast_err = 1'b0;
                de_start = 1'b0;
            end
            if (n == err_at) begin
                chk("err_stb", stb(), 0);
                chk("err", de_err, 1);
                chk("err_busy", de_busy, 0);
                chk("err_done", de_done, 0);
                tick;
                chk("err_go", mast_go, 0);
                chk("err_pulse", de_err, 0);
                return;
            end
            chk("stb", stb(), n == 0 ? 5'b11000 : n == 1 ? 5'b00100 : n == 2 ? 5'b00010 : 5'b00001);
            chk("err0", de_err, 0);
            if (n == 0) begin
                chk("txsz", de_txsz, w[0] & 32'hFFF);
                chk("csr", de_csr, w[0]);
            end
            if (n == 1) chk("adr0", de_adr0, w[1]);
            if (n == 2) chk("adr1", de_adr1, w[2]);
            if (n == 3) chk("nptr", de_csr, w[3]);
        end
        chk("fin_busy", de_busy, 1);
        chk("fin_go", mast_go, 0);
        chk("fin_done", de_done, 0);
        tick;
        chk("done", de_done, 1);
        chk("done_busy", de_busy, 0);
        chk("ch", de_ch_sel, ch);
        chk("done_stb", stb(), 0);
        tick;
        chk("done_pulse", de_done, 0);
        chk("ch_hold", de_ch_sel, ch);
    endtask
    initial begin
        tick;
        tick;
        chk("rst_busy", de_busy, 0);
        chk("rst_go", mast_go, 0);
        chk("rst_we", mast_we, 0);
        chk("rst_adr", mast_adr, 0);
        chk("rst_flags", {de_done, de_err, stb()}, 0);
        chk("rst_csr", de_csr, 0);
        rst = 1'b1;
        tick;
        // nominal fetch, data beat every cycle: done lands in cycle 6
        w[0] = 32'h0011_0040; w[1] = 32'hA000_0000; w[2] = 32'hB000_0000; w[3] = 32'h0000_2001;
        do_fetch(32'h0000_1001, 5'd3, 0, 4);
        // invalid pointer: error pulse, no bus access
        pointer = 32'h0000_1000;
        de_start = 1'b1;
        tick;
        de_start = 1'b0;
        chk("inv_err", de_err, 1);
        chk("inv_go", mast_go, 0);
        chk("inv_busy", de_busy, 0);
        tick;
        chk("inv_pulse", de_err, 0);
        chk("inv_go2", mast_go, 0);
        // three wait states per word: done lands in cycle 18
        w[0] = 32'h0010_0123; w[1] = 32'h1111_2220; w[2] = 32'h3333_4440; w[3] = 32'h0000_5001;
        do_fetch(32'h0000_1001, 5'd9, 3, 4);
        // bus error on word2, then a clean fetch at the top of the address space
        do_fetch(32'h0000_2001, 5'd1, 0, 2);
        chk("err_adr1_held", de_adr1, 32'h3333_4440);
        w[0] = 32'h0000_0FFF; w[1] = 32'h1234_5678; w[2] = 32'h8765_4321; w[3] = 32'h0000_0000;
        do_fetch(32'hFFFF_FFF1, 5'd31, 1, 4);
        // abort in RD1 together with a data beat
        pointer = 32'h0000_4001;
        ch_sel = 5'd2;
        de_start = 1'b1;
        tick;
        de_start = 1'b0;
        mast_drdy = 1'b1;
        mast_din = 32'h0000_0010;
        tick;
        chk("ab_csr_we", de_csr_we, 1);
        mast_din = 32'hDEAD_BEEF;
        de_abort = 1'b1;
        tick;
        mast_drdy = 1'b0;
        de_abort = 1'b0;
        chk("ab_stb", stb(), 0);
        chk("ab_busy", de_busy, 0);
        chk("ab_go", mast_go, 0);
        chk("ab_adr0", de_adr0, 32'h1234_5678);
        tick;
        chk("ab_flags", {de_done, de_err}, 0);
        // reset asserted in RD2
        pointer = 32'h0000_5001;
        ch_sel = 5'd6;
        de_start = 1'b1;
        tick;
        de_start = 1'b0;
        mast_drdy = 1'b1;
        tick;
        tick;
        mast_drdy = 1'b0;
        chk("rs_in_rd2", mast_adr, 32'h0000_5008);
        rst = 1'b0;
        tick;
        chk("rs_go", mast_go, 0);
        chk("rs_busy", de_busy, 0);
        chk("rs_adr", mast_adr, 0);
        chk("rs_data", de_csr | de_adr0 | de_adr1 | 32'(de_txsz), 0);
        chk("rs_ch", de_ch_sel, 0);
        chk("rs_flags", {de_done, de_err, stb()}, 0);
        rst = 1'b1;
        tick;
        // long stall: no watchdog in the default build, request stays up until abort
        pointer = 32'h0000_6001;
        ch_sel = 5'd4;
        de_start = 1'b1;
        tick;
        de_start = 1'b0;
        for (int i = 0; i < 20; i++) tick;
        chk("st_go", mast_go, 1);
        chk("st_adr", mast_adr, 32'h0000_6000);
        chk("st_err", de_err, 0);
        de_abort = 1'b1;
        tick;
        de_abort = 1'b0;
        chk("st_busy", de_busy, 0);
        tick;
        chk("st_flags", {de_done, de_err, stb()}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
